// File: rtl/early_stop_multi_pkg.sv
// Shared types and helpers for the early-stop detector: FSM encoding,
// code-select constants and the code-to-active-syndrome mask.
package early_stop_multi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HIT  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   localparam logic [1:0] CODE_A = 2'b00;
   localparam logic [1:0] CODE_B = 2'b01;
   localparam logic [1:0] CODE_C = 2'b10;

   // Short codes only carry the lower half of the syndromes; callers truncate to NUM_SYN.
   function automatic logic [31:0] code_mask(input logic [1:0] code, input int unsigned num_syn);
      logic [31:0] m;
      m = 32'h0000_0000;
      for (int i = 0; i < 32; i++) begin
         case (code)
            CODE_A, CODE_B: m[i] = (i < int'(num_syn / 2));
            CODE_C:         m[i] = (i < int'(num_syn));
            default:        m[i] = (i < int'(num_syn));
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/early_stop_multi_if.sv
// Syndrome-side bus into the early-stop detector: frame control plus one
// test pattern's flattened syndromes per valid beat.
interface early_stop_multi_if #(
   parameter int SYN_W   = 10,
   parameter int NUM_SYN = 4
);
   logic                       i_frame_start;
   logic                       i_mode;
   logic [1:0]                 i_code;
   logic [NUM_SYN*SYN_W-1:0]   i_syn;
   logic                       i_syn_valid;

   modport master (
      output i_frame_start, i_mode, i_code, i_syn, i_syn_valid
   );

   modport slave (
      input  i_frame_start, i_mode, i_code, i_syn, i_syn_valid
   );
endinterface

// File: rtl/early_stop_multi_pulser.sv
// Edge-to-pulse converter; i_clear restarts edge history so a fresh frame can pulse at once.
module pulser (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_level,
   output logic o_pulse
);
   logic r_prev;
   logic r_pulse;

   // Registered one-cycle pulse on a rising level, or on any level coincident with clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else if (i_clear) begin
         r_prev  <= i_level;
         r_pulse <= i_level;
      end else begin
         r_prev  <= i_level;
         r_pulse <= i_level & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;
endmodule

// File: rtl/early_stop_multi_syn_zero_check.sv
// Combinational zero test over the masked syndrome slices (S1 in the lowest slice).
module syn_zero_check #(
   parameter int SYN_W   = 10,
   parameter int NUM_SYN = 4
) (
   input  logic [NUM_SYN*SYN_W-1:0] i_syn,
   input  logic [NUM_SYN-1:0]       i_mask,
   output logic                     o_zero
);
   logic w_zero;

   // Any active nonzero slice breaks the zero condition.
   always_comb begin
      w_zero = 1'b1;
      for (int i = 0; i < NUM_SYN; i++) begin
         if (i_mask[i] && (i_syn[i*SYN_W +: SYN_W] != {SYN_W{1'b0}})) begin
            w_zero = 1'b0;
         end else begin
            w_zero = w_zero;
         end
      end
   end

   assign o_zero = w_zero;
endmodule

// File: rtl/early_stop_multi.sv
// Early-stop detector for the Chase decoder path: flags the first all-zero
// test pattern of a frame, or that none of the expected patterns was zero.
module early_stop_multi
   import early_stop_multi_pkg::*;
#(
   parameter int SYN_W   = 10,
   parameter int NUM_SYN = 4,
   parameter int NUM_TP  = 4,
   parameter int TP_W    = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   early_stop_multi_if.slave bus,
   output logic              o_early_stop_pulse,
   output logic [TP_W-1:0]   o_stop_tp_idx,
   output logic              o_no_stop_pulse,
   output logic              o_busy
);
   state_t            r_state;
   logic [TP_W-1:0]   r_cnt;
   logic              r_mode;
   logic [1:0]        r_code;
   logic [TP_W-1:0]   r_idx;

   logic              w_eff_mode;
   logic [1:0]        w_eff_code;
   logic [TP_W-1:0]   w_eff_cnt;
   logic [TP_W-1:0]   w_last;
   logic [NUM_SYN-1:0] w_mask;
   logic              w_zero;
   logic              w_eval;
   logic              w_hit_evt;
   logic              w_nostop_evt;

   // A frame_start beat is judged against the incoming mode/code as TP 0 of the new frame.
   assign w_eff_mode   = bus.i_frame_start ? bus.i_mode : r_mode;
   assign w_eff_code   = bus.i_frame_start ? bus.i_code : r_code;
   assign w_eff_cnt    = bus.i_frame_start ? TP_W'(0) : r_cnt;
   assign w_last       = w_eff_mode ? TP_W'(NUM_TP - 1) : TP_W'(0);
   assign w_mask       = NUM_SYN'(code_mask(w_eff_code, NUM_SYN));
   assign w_eval       = bus.i_syn_valid & (bus.i_frame_start | (r_state == ST_RUN));
   assign w_hit_evt    = w_eval & w_zero;
   assign w_nostop_evt = w_eval & ~w_zero & (w_eff_cnt == w_last);

   syn_zero_check #(
      .SYN_W   (SYN_W),
      .NUM_SYN (NUM_SYN)
   ) u_zero (
      .i_syn  (bus.i_syn),
      .i_mask (w_mask),
      .o_zero (w_zero)
   );

   // Frame FSM, TP counter, latched frame parameters and reported TP index.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= TP_W'(0);
         r_mode  <= 1'b0;
         r_code  <= 2'b00;
         r_idx   <= TP_W'(0);
      end else begin
         if (bus.i_frame_start) begin
            r_mode <= bus.i_mode;
            r_code <= bus.i_code;
         end else begin
            r_mode <= r_mode;
            r_code <= r_code;
         end

         if (w_hit_evt) begin
            r_idx <= w_eff_cnt;
         end else if (bus.i_frame_start) begin
            r_idx <= TP_W'(0);
         end else begin
            r_idx <= r_idx;
         end

         if (w_hit_evt) begin
            r_state <= ST_HIT;
            r_cnt   <= w_eff_cnt;
         end else if (w_nostop_evt) begin
            r_state <= ST_DONE;
            r_cnt   <= w_eff_cnt;
         end else if (w_eval) begin
            r_state <= ST_RUN;
            r_cnt   <= w_eff_cnt + TP_W'(1);
         end else if (bus.i_frame_start) begin
            r_state <= ST_RUN;
            r_cnt   <= TP_W'(0);
         end else begin
            case (r_state)
               ST_IDLE, ST_RUN, ST_HIT, ST_DONE: r_state <= r_state;
               default:                          r_state <= ST_IDLE;
            endcase
            r_cnt <= r_cnt;
         end
      end
   end

   pulser u_hit_pulse (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (bus.i_frame_start),
      .i_level (w_hit_evt),
      .o_pulse (o_early_stop_pulse)
   );

   pulser u_nostop_pulse (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (bus.i_frame_start),
      .i_level (w_nostop_evt),
      .o_pulse (o_no_stop_pulse)
   );

   assign o_stop_tp_idx = r_idx;
   assign o_busy        = (r_state == ST_RUN);
endmodule

// File: tb/tb_early_stop_multi.sv
// Directed bench for early_stop_multi: hand-computed pulse/index/busy expectations per step.
module tb_early_stop_multi;
   localparam int SYN_W   = 10;
   localparam int NUM_SYN = 4;
   localparam int NUM_TP  = 4;
   localparam int TP_W    = 2;

   logic            clk;
   logic            rst_n;
   logic            early;
   logic [TP_W-1:0] idx;
   logic            nostop;
   logic            busy;
   int              checks;
   int              fails;

   early_stop_multi_if #(.SYN_W(SYN_W), .NUM_SYN(NUM_SYN)) bus ();

   early_stop_multi #(
      .SYN_W(SYN_W), .NUM_SYN(NUM_SYN), .NUM_TP(NUM_TP), .TP_W(TP_W)
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .bus                (bus.slave),
      .o_early_stop_pulse (early),
      .o_stop_tp_idx      (idx),
      .o_no_stop_pulse    (nostop),
      .o_busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check all four outputs in one go.
   task automatic chk_out(input string tag, input logic e, input logic [TP_W-1:0] i,
                          input logic n, input logic b);
      chk({tag, ".early"},  {31'd0, early},  {31'd0, e});
      chk({tag, ".idx"},    {30'd0, idx},    {30'd0, i});
      chk({tag, ".nostop"}, {31'd0, nostop}, {31'd0, n});
      chk({tag, ".busy"},   {31'd0, busy},   {31'd0, b});
   endtask

   // One clock with the given inputs applied; returns #1 after the edge with inputs idle.
   task automatic drive(input logic fs, input logic mode, input logic [1:0] code,
                        input logic vld, input logic [39:0] syn);
      bus.i_frame_start = fs;
      bus.i_mode        = mode;
      bus.i_code        = code;
      bus.i_syn_valid   = vld;
      bus.i_syn         = syn;
      @(posedge clk);
      #1;
      bus.i_frame_start = 1'b0;
      bus.i_syn_valid   = 1'b0;
      bus.i_syn         = 40'd0;
   endtask

   // syn layout {S7,S5,S3,S1}
   initial begin
      checks = 0;
      fails  = 0;
      rst_n  = 1'b0;
      bus.i_frame_start = 1'b0;
      bus.i_mode        = 1'b0;
      bus.i_code        = 2'b00;
      bus.i_syn         = 40'd0;
      bus.i_syn_valid   = 1'b0;
      #12;
      chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Hard mode, code C, single zero beat.
      drive(1'b1, 1'b0, 2'b10, 1'b0, 40'd0);
      chk_out("hard_open", 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 2'b10, 1'b1, 40'd0);
      chk_out("hard_hit", 1'b1, 2'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 2'b10, 1'b0, 40'd0);
      chk_out("hard_hit_after", 1'b0, 2'd0, 1'b0, 1'b0);

      // Soft mode, hit on TP2, TP3 ignored.
      drive(1'b1, 1'b1, 2'b10, 1'b0, 40'd0);
      drive(1'b0, 1'b1, 2'b10, 1'b1, {10'h000, 10'h013, 10'h000, 10'h000});
      chk_out("soft_tp0", 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 2'b10, 1'b1, {10'h000, 10'h000, 10'h000, 10'h001});
      chk_out("soft_tp1", 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 2'b10, 1'b1, 40'd0);
      chk_out("soft_tp2_hit", 1'b1, 2'd2, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 2'b10, 1'b1, 40'd0);
      chk_out("soft_tp3_ignored", 1'b0, 2'd2, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 2'b10, 1'b0, 40'd0);
      chk_out("soft_idx_held", 1'b0, 2'd2, 1'b0, 1'b0);

      // Code A masks S5/S7: nonzero S7 still a hit on TP0; idx cleared at frame_start.
      drive(1'b1, 1'b1, 2'b00, 1'b0, 40'd0);
      chk_out("codeA_open", 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 2'b00, 1'b1, {10'h3FF, 10'h000, 10'h000, 10'h000});
      chk_out("codeA_masked_hit", 1'b1, 2'd0, 1'b0, 1'b0);

      // Code B hard mode: S3 is active, nonzero -> no-stop after the single beat.
      drive(1'b1, 1'b0, 2'b01, 1'b0, 40'd0);
      drive(1'b0, 1'b0, 2'b01, 1'b1, {10'h000, 10'h000, 10'h004, 10'h000});
      chk_out("codeB_hard_nostop", 1'b0, 2'd0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 2'b01, 1'b0, 40'd0);
      chk_out("codeB_nostop_after", 1'b0, 2'd0, 1'b0, 1'b0);

      // Soft mode, four nonzero beats -> no-stop after the fourth, DONE ignores beats.
      drive(1'b1, 1'b1, 2'b10, 1'b0, 40'd0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 2'b10, 1'b1, {10'h000, 10'h000, 10'h2A5, 10'h000});
         chk_out("soft_nz_beat", 1'b0, 2'd0, 1'b0, 1'b1);
      end
      drive(1'b0, 1'b1, 2'b10, 1'b1, {10'h000, 10'h000, 10'h2A5, 10'h000});
      chk_out("soft_nostop", 1'b0, 2'd0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 2'b10, 1'b1, 40'd0);
      chk_out("done_ignores_beat", 1'b0, 2'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 2'b10, 1'b0, 40'd0);
      chk_out("done_quiet", 1'b0, 2'd0, 1'b0, 1'b0);

      // Abort at counter 2 with a coincident frame_start + zero beat.
      drive(1'b1, 1'b1, 2'b10, 1'b0, 40'd0);
      drive(1'b0, 1'b1, 2'b10, 1'b1, {10'h001, 10'h000, 10'h000, 10'h000});
      drive(1'b0, 1'b1, 2'b10, 1'b1, {10'h001, 10'h000, 10'h000, 10'h000});
      chk_out("abort_pre", 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 2'b10, 1'b1, 40'd0);
      chk_out("abort_new_hit", 1'b1, 2'd0, 1'b0, 1'b0);

      // Coincident start uses the new code: code A ignores S7 even though old latch was C.
      drive(1'b1, 1'b1, 2'b10, 1'b0, 40'd0);
      drive(1'b1, 1'b1, 2'b00, 1'b1, {10'h155, 10'h000, 10'h000, 10'h000});
      chk_out("coincident_new_code", 1'b1, 2'd0, 1'b0, 1'b0);

      // Reset lands right at the edge the pulse would register.
      drive(1'b1, 1'b1, 2'b10, 1'b0, 40'd0);
      drive(1'b0, 1'b1, 2'b10, 1'b1, {10'h000, 10'h000, 10'h000, 10'h009});
      bus.i_syn_valid = 1'b1;
      bus.i_syn       = 40'd0;
      @(posedge clk);
      rst_n = 1'b0;
      bus.i_syn_valid = 1'b0;
      #1;
      chk_out("reset_mid_frame", 1'b0, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_out("reset_held", 1'b0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Next frame after reset: soft, code 3 (full mask), S7 nonzero then zero beat.
      drive(1'b1, 1'b1, 2'b11, 1'b0, 40'd0);
      drive(1'b0, 1'b1, 2'b11, 1'b1, {10'h200, 10'h000, 10'h000, 10'h000});
      chk_out("post_reset_tp0", 1'b0, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 2'b11, 1'b1, 40'd0);
      chk_out("post_reset_hit", 1'b1, 2'd1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
